// File: rtl/taillight_sequencer.sv
// ---------------------------------------------------------------------------
// taillight_sequencer
//
// Sequences the six tail-light lamps (three per side) from level-sensitive
// driver requests. Requests are arbitrated in IDLE with this priority:
// hazard, then left alone, then right alone. The granted mode is latched and
// the lamp pattern steps once per phase. An internal prescaler sets the phase
// length to DIV clock cycles.
//
// Optional feature macro: TAILLIGHT_BRAKE_EN adds the `brake` input. When it
// is high, brake lighting is ORed into the lamp outputs. It never affects
// the state, the phase or the prescaler.
//
// Parameters
//   DIV_W   width of the phase prescaler counter
//   DIV     clock cycles per lamp phase, 1 .. 2**DIV_W-1
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous reset, active low
//   left/right       turn requests, level
//   hazard           hazard request, level
//   brake            brake request, level (TAILLIGHT_BRAKE_EN only)
//   la, lb, lc       left lamps, la innermost (registered)
//   ra, rb, rc       right lamps, ra innermost (registered)
//   busy             high whenever the sequencer is not IDLE (registered)
//   phase            current phase index 0..3 (registered)
// ---------------------------------------------------------------------------
module taillight_sequencer #(
    parameter int DIV_W = 4,
    parameter int DIV   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic       brake,
`endif
    output logic       la,
    output logic       lb,
    output logic       lc,
    output logic       ra,
    output logic       rb,
    output logic       rc,
    output logic       busy,
    output logic [1:0] phase
);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_t;

    state_t             state, state_d;
    logic [1:0]         phase_d;
    logic [DIV_W-1:0]   cnt, cnt_d;
    logic [5:0]         lamp_d, lamp_q;   // {la, lb, lc, ra, rb, rc}
    logic               busy_d;
    logic               phase_end;
    logic               turn_hold;
    logic [2:0]         fill;

    assign phase_end = (cnt == DIV_W'(DIV - 1));

    // The active direction is still requested on its own, so the turn repeats.
    assign turn_hold = (state == LEFT) ? (left && !right) : (right && !left);

    // State register. The lamps and busy are registered from the next-state
    // values. This keeps them aligned with `phase` and avoids any
    // combinational path from an input to an output.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            phase  <= 2'd0;
            cnt    <= '0;
            lamp_q <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_d;
            phase  <= phase_d;
            cnt    <= cnt_d;
            lamp_q <= lamp_d;
            busy   <= busy_d;
        end
    end

    // Next-state logic: arbitration in IDLE and phase stepping otherwise.
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state;
        phase_d = phase;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                phase_d = 2'd0;
                cnt_d   = '0;
                if (hazard) begin
                    state_d = HAZARD;
                    phase_d = 2'd1;
                end else if (left && !right) begin
                    state_d = LEFT;
                    phase_d = 2'd1;
                end else if (right && !left) begin
                    state_d = RIGHT;
                    phase_d = 2'd1;
                end
            end
            LEFT, RIGHT: begin
                if (!phase_end) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d = '0;
                    // A hazard request preempts at any phase end.
                    if (hazard) begin
                        state_d = HAZARD;
                        phase_d = 2'd1;
                    end else if (phase != 2'd0) begin
                        phase_d = phase + 2'd1;   // 1->2->3->0
                    end else if (turn_hold) begin
                        phase_d = 2'd1;
                    end else begin
                        state_d = IDLE;
                        phase_d = 2'd0;
                    end
                end
            end
            HAZARD: begin
                if (!phase_end) begin
                    cnt_d = cnt + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (phase == 2'd1) begin
                        phase_d = 2'd0;
                    end else if (hazard) begin
                        phase_d = 2'd1;
                    end else begin
                        state_d = IDLE;
                        phase_d = 2'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = 2'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: lamp pattern for the state and phase being entered.
    always_comb begin
        // Thermometer fill for one side: phase 1 -> a, 2 -> a,b, 3 -> a,b,c.
        fill   = {phase_d != 2'd0, phase_d[1], phase_d == 2'd3};
        lamp_d = '0;
        busy_d = (state_d != IDLE);
        unique case (state_d)
            LEFT:    lamp_d[5:3] = fill;
            RIGHT:   lamp_d[2:0] = fill;
            HAZARD:  lamp_d      = (phase_d == 2'd1) ? 6'b111111 : 6'b000000;
            default: lamp_d      = '0;
        endcase
`ifdef TAILLIGHT_BRAKE_EN
        // Brake lights every lamp that is not part of an active turn sequence.
        if (brake) begin
            unique case (state_d)
                LEFT:    lamp_d[2:0] = 3'b111;
                RIGHT:   lamp_d[5:3] = 3'b111;
                default: lamp_d      = 6'b111111;
            endcase
        end
`endif
    end

    assign {la, lb, lc, ra, rb, rc} = lamp_q;

endmodule

// File: tb/tb_taillight_sequencer.sv
// ---------------------------------------------------------------------------
// tb_taillight_sequencer
//
// Self-checking bench for taillight_sequencer. Two instances share the same
// inputs, one built with DIV=2 and one with DIV=3. The bench runs a
// directed vector table, a few hand-written multi-cycle sequences, and then
// randomized traffic. The randomized traffic is checked against a reference
// model that tracks the cycle position inside the current sequence.
// Define TAILLIGHT_BRAKE_EN to exercise the brake input.
// ---------------------------------------------------------------------------
module tb_taillight_sequencer;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic left   = 1'b0;
    logic right  = 1'b0;
    logic hazard = 1'b0;
    logic brake  = 1'b0;

    logic [5:0] lamps2, lamps3;    // {la, lb, lc, ra, rb, rc}
    logic       busy2,  busy3;
    logic [1:0] phase2, phase3;

    always #5 clk = ~clk;

    taillight_sequencer #(.DIV_W(4), .DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake(brake),
`endif
        .la(lamps2[5]), .lb(lamps2[4]), .lc(lamps2[3]),
        .ra(lamps2[2]), .rb(lamps2[1]), .rc(lamps2[0]),
        .busy(busy2), .phase(phase2)
    );

    taillight_sequencer #(.DIV_W(4), .DIV(3)) u_dut3 (
        .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake(brake),
`endif
        .la(lamps3[5]), .lb(lamps3[4]), .lc(lamps3[3]),
        .ra(lamps3[2]), .rb(lamps3[1]), .rc(lamps3[0]),
        .busy(busy3), .phase(phase3)
    );

    // Observation vectors: {busy, phase, lamps}
    wire [8:0] obs2 = {busy2, phase2, lamps2};
    wire [8:0] obs3 = {busy3, phase3, lamps3};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got busy/phase/lamps=%b required %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse in mid-cycle with no clock edge inside it.
    task automatic do_reset();
        left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
        #1 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Each instance is described by its mode and by a cycle position k within
    // the current sequence. A turn sequence lasts 4*DIV cycles and a hazard
    // sequence lasts 2*DIV cycles. The phase and lamps are derived from k.
    typedef enum {M_IDLE, M_TURN, M_HAZ} mmode_t;
    mmode_t m_mode [2];
    bit     m_left [2];
    int     m_k    [2];
    bit     m_brake;
    int     divs   [2] = '{2, 3};

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_mode[i] <= M_IDLE;
                m_k[i]    <= 0;
                m_left[i] <= 1'b0;
            end
            m_brake <= 1'b0;
        end else begin
            m_brake <= brake;
            for (int i = 0; i < 2; i++) begin
                int  d;
                bit  same, opp;
                d    = divs[i];
                same = m_left[i] ? left  : right;
                opp  = m_left[i] ? right : left;
                case (m_mode[i])
                    M_IDLE: begin
                        if (hazard) begin
                            m_mode[i] <= M_HAZ;
                            m_k[i]    <= 0;
                        end else if (left != right) begin
                            m_mode[i] <= M_TURN;
                            m_left[i] <= left;
                            m_k[i]    <= 0;
                        end
                    end
                    M_TURN: begin
                        if ((m_k[i] % d) == d - 1 && hazard) begin
                            m_mode[i] <= M_HAZ;
                            m_k[i]    <= 0;
                        end else if (m_k[i] == 4 * d - 1) begin
                            if (same && !opp) m_k[i] <= 0;
                            else              m_mode[i] <= M_IDLE;
                        end else begin
                            m_k[i] <= m_k[i] + 1;
                        end
                    end
                    default: begin
                        if (m_k[i] == 2 * d - 1) begin
                            if (hazard) m_k[i] <= 0;
                            else        m_mode[i] <= M_IDLE;
                        end else begin
                            m_k[i] <= m_k[i] + 1;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [8:0] model_exp(input int i);
        logic [5:0] lm;
        logic [2:0] th;
        logic [1:0] ph;
        logic       b;
        int         n;
        lm = '0; ph = '0; b = 1'b0;
        case (m_mode[i])
            M_TURN: begin
                n  = (m_k[i] / divs[i] + 1) % 4;    // lamps lit on the active side
                ph = 2'(n);
                th = {n >= 1, n >= 2, n >= 3};
                lm = m_left[i] ? {th, 3'b000} : {3'b000, th};
                b  = 1'b1;
            end
            M_HAZ: begin
                n  = (m_k[i] / divs[i] + 1) % 2;
                ph = 2'(n);
                lm = (n == 1) ? 6'b111111 : 6'b000000;
                b  = 1'b1;
            end
            default: ;
        endcase
        if (m_brake) begin
            if (m_mode[i] == M_TURN) begin
                if (m_left[i]) lm[2:0] = 3'b111;
                else           lm[5:3] = 3'b111;
            end else begin
                lm = 6'b111111;
            end
        end
        return {b, ph, lm};
    endfunction

    // ---------------- directed vector table (DIV=2 instance) ----------------
    typedef struct {
        logic       l, r, h;
        logic [8:0] exp;      // {busy, phase, lamps} after the edge
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic l, input logic r, input logic h,
                                input logic b, input logic [1:0] ph, input logic [5:0] lm);
        vec_t v;
        v.l = l; v.r = r; v.h = h; v.exp = {b, ph, lm};
        return v;
    endfunction

    initial begin
        logic [5:0] brk_seq [8];

        // Left pulse: la, la+lb, la+lb+lc, off, then IDLE.
        tbl.push_back(mk(1, 0, 0, 1, 2'd1, 6'b100000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd1, 6'b100000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd2, 6'b110000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd2, 6'b110000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd3, 6'b111000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd3, 6'b111000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd0, 6'b000000));
        tbl.push_back(mk(0, 0, 0, 1, 2'd0, 6'b000000));
        tbl.push_back(mk(0, 0, 0, 0, 2'd0, 6'b000000));
        // Right held: the pattern repeats with a period of 8 cycles.
        for (int rep = 0; rep < 2; rep++) begin
            tbl.push_back(mk(0, 1, 0, 1, 2'd1, 6'b000100));
            tbl.push_back(mk(0, 1, 0, 1, 2'd1, 6'b000100));
            tbl.push_back(mk(0, 1, 0, 1, 2'd2, 6'b000110));
            tbl.push_back(mk(0, 1, 0, 1, 2'd2, 6'b000110));
            tbl.push_back(mk(0, 1, 0, 1, 2'd3, 6'b000111));
            tbl.push_back(mk(0, 1, 0, 1, 2'd3, 6'b000111));
            tbl.push_back(mk(0, 1, 0, 1, 2'd0, 6'b000000));
            tbl.push_back(mk(0, 1, 0, 1, 2'd0, 6'b000000));
        end
        // Both turns requested: the sequence ends and then stays IDLE.
        for (int j = 0; j < 10; j++)
            tbl.push_back(mk(1, 1, 0, 0, 2'd0, 6'b000000));
        // Right dropped: LEFT is entered on the next edge.
        tbl.push_back(mk(1, 0, 0, 1, 2'd1, 6'b100000));

        // ---- reset state ----
        tick();
        check("reset_dut2", obs2, 9'd0);
        check("reset_dut3", obs3, 9'd0);
        reset = 1'b1;

        // ---- table ----
        foreach (tbl[i]) begin
            left = tbl[i].l; right = tbl[i].r; hazard = tbl[i].h;
            tick();
            check($sformatf("vec%0d", i), obs2, tbl[i].exp);
        end

        // ---- hazard preempting LEFT phase 2 (DIV=3 instance) ----
        tick();
        do_reset();
        left = 1'b1;
        tick();
        left = 1'b0;
        repeat (3) tick();
        check("haz_pre_ph2", obs3, {1'b1, 2'd2, 6'b110000});
        hazard = 1'b1;
        tick(); check("haz_wait1", obs3, {1'b1, 2'd2, 6'b110000});
        tick(); check("haz_wait2", obs3, {1'b1, 2'd2, 6'b110000});
        tick(); check("haz_on0",   obs3, {1'b1, 2'd1, 6'b111111});
        hazard = 1'b0;
        tick(); check("haz_on1",   obs3, {1'b1, 2'd1, 6'b111111});
        tick(); check("haz_on2",   obs3, {1'b1, 2'd1, 6'b111111});
        tick(); check("haz_off0",  obs3, {1'b1, 2'd0, 6'b000000});
        tick(); check("haz_off1",  obs3, {1'b1, 2'd0, 6'b000000});
        tick(); check("haz_off2",  obs3, {1'b1, 2'd0, 6'b000000});
        tick(); check("haz_idle",  obs3, 9'd0);

        // ---- asynchronous reset in RIGHT phase 3 (DIV=2 instance) ----
        do_reset();
        right = 1'b1;
        repeat (5) tick();
        check("rst_pre_ph3", obs2, {1'b1, 2'd3, 6'b000111});
        #1 reset = 1'b0;
        #1;
        check("rst_async_dut2", obs2, 9'd0);
        check("rst_async_dut3", obs3, 9'd0);
        #1 reset = 1'b1;
        tick();
        check("rst_restart", obs2, {1'b1, 2'd1, 6'b000100});
        right = 1'b0;

`ifdef TAILLIGHT_BRAKE_EN
        // ---- brake (DIV=2 instance) ----
        do_reset();
        brake = 1'b1;
        tick();
        check("brake_idle", obs2, {1'b0, 2'd0, 6'b111111});
        brk_seq = '{6'b100111, 6'b100111, 6'b110111, 6'b110111,
                    6'b111111, 6'b111111, 6'b000111, 6'b000111};
        left = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            left = 1'b0;
            check($sformatf("brake_left%0d", j), obs2,
                  {1'b1, 2'((j / 2 + 1) % 4), brk_seq[j]});
        end
        brake = 1'b0;
`else
        brk_seq = '{default: '0};
`endif

        // ---- randomized traffic against the reference model ----
        tick();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            check($sformatf("rand_dut2_c%0d", c), obs2, model_exp(0));
            check($sformatf("rand_dut3_c%0d", c), obs3, model_exp(1));
            // Inputs change only occasionally, which gives long holds.
            if ($urandom_range(0, 5) == 0) left   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) right  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) hazard = ($urandom_range(0, 4) == 0);
`ifdef TAILLIGHT_BRAKE_EN
            if ($urandom_range(0, 7) == 0) brake  = $urandom_range(0, 1) == 1;
`endif
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/taillight_sequencer.md
# taillight_sequencer

Controller that sequences the six tail-light lamps (three per side) from driver requests. Arbitrates left-turn, right-turn and hazard requests, latches the granted mode, and steps the lamp pattern with an internal phase prescaler. Sits between the raw switch inputs and the lamp drivers; all lamp outputs are registered.

## Interface
- `DIV_W`, default 4: width of the phase prescaler counter.
- `DIV`, default 10: clock cycles per lamp phase; legal range 1 to 2^DIV_W−1.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `left`  in  1  left-turn request, level.
- `right`  in  1  right-turn request, level.
- `hazard`  in  1  hazard request, level.
- `brake`  in  1  brake request, level; present only with `TAILLIGHT_BRAKE_EN`.
- `la`, `lb`, `lc`  out  1 each  left lamps, `la` innermost.
- `ra`, `rb`, `rc`  out  1 each  right lamps, `ra` innermost.
- `busy`  out  1  high whenever state is not IDLE.
- `phase`  out  2  current phase index 0–3.

## Operation
- States: IDLE, LEFT, RIGHT, HAZARD. Phase counter `phase` (2 bits) and prescaler `cnt` (DIV_W bits).
- IDLE arbitration, evaluated every cycle, priority: `hazard` → HAZARD; `left` alone → LEFT; `right` alone → RIGHT; `left`&`right` without `hazard` → stay IDLE. Accepting a request sets `phase`=1, `cnt`=0.
- Phase end: a cycle with `cnt`==DIV−1. At phase end `cnt` returns to 0; otherwise `cnt` increments.
- LEFT/RIGHT pattern on the active side, other side off: phase 1 → a; phase 2 → a,b; phase 3 → a,b,c; phase 0 → all off.
- LEFT/RIGHT sequencing at phase end: 1→2→3→0. At end of phase 0: if `hazard`, → HAZARD (phase 1); else if the same direction's request is still high and the opposite is low, restart at phase 1; else → IDLE (phase 0).
- `left`/`right` changes during phases 1–3 are ignored; the sequence always completes through phase 0.
- `hazard` during LEFT/RIGHT phases 1–3: preempts at the next phase end → HAZARD, `phase`=1.
- HAZARD: phase 1 → all six on; phase 0 → all six off. At phase end 1→0. At end of phase 0: `hazard` high → phase 1; else → IDLE.
- IDLE: all lamps off, `phase`=0, `cnt`=0.
- Reset (any time, including mid-sequence): state IDLE, `phase`=0, `cnt`=0, all lamps 0, `busy`=0.

## Timing
- Requests sampled at rising edge t in IDLE; lamps and `busy` show phase 1 from t+1 (1-cycle latency).
- Each phase holds exactly DIV cycles. A full LEFT/RIGHT cycle is 4·DIV cycles. A full HAZARD cycle is 2·DIV cycles.
- DIV=1: the phase advances every cycle.
- Phase-end decisions use the inputs sampled on the phase-end edge. The new pattern is visible the following cycle.
- Lamp outputs, `busy` and `phase` are all registered, with no combinational input-to-output path.
- Reset deassertion takes effect synchronously: the first possible request acceptance is the first rising edge after `reset` is high.

## Configuration
- `TAILLIGHT_BRAKE_EN` defined: `brake` port exists. With `brake` high:
  - IDLE: all six lamps on.
  - LEFT: right lamps all on; left lamps follow the sequence.
  - RIGHT: left lamps all on; right lamps follow the sequence.
  - HAZARD: all six lamps on in both phases.
  - `brake` never changes state, `phase` or `cnt`; it only ORs into the registered lamp outputs, with 1-cycle latency.
- Not defined: `brake` port is absent and lamp logic is exactly as in Operation.

## Test plan
- DIV=2, pulse `left` for 1 cycle → `la` at t+1; `la,lb` at t+3; `la,lb,lc` at t+5; all off at t+7; IDLE with `busy`=0 at t+9.
- DIV=2, hold `right` continuously → `ra` / `ra,rb` / `ra,rb,rc` / off repeats with period 8 cycles; left lamps stay 0 throughout.
- DIV=2, `left`=`right`=1 for 10 cycles → lamps 0, `busy`=0 throughout; then drop `right` → LEFT entered next cycle.
- DIV=3, in LEFT phase 2, raise `hazard` → at the phase end, all six lamps on for 3 cycles, then off for 3 cycles; drop `hazard` → IDLE after the off phase.
- Assert `reset` low mid-RIGHT phase 3 → all outputs 0 immediately, with no clock edge required; after release, `right` restarts at phase 1.
- `TAILLIGHT_BRAKE_EN`, DIV=2, `brake`=1 with `left` → `ra,rb,rc`=1 constant while the left lamps sequence; `brake`=1 in IDLE → all six lamps 1 next cycle.
